sm_input_debounce: RTL and testbench



---
 rtl/sm_input_debounce.sv | 96 +++++++++
 tb/tb_sm_input_debounce.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sm_input_debounce.sv
// Board-input conditioner: two-flop synchroniser, per-bit stability counter,
// registered rise/fall strobes and a sticky change-event flag with ack.
module sm_input_debounce #(
    parameter int               WIDTH           = 6,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
    input  logic             clkIn,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    input  logic             evt_ack
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // Terminal count: the accepting edge is the DEBOUNCE_CYCLES-th consecutive disagreement.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             evt_q;
    logic             evt_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Next-state: per-bit stability counters, acceptance and strobe generation.
    always_comb begin
        data_d = data_q;
        rise_d = {WIDTH{1'b0}};
        fall_d = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = {CW{1'b0}};
            if (sync2_q[i] == data_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] < CNT_LAST) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                data_d[i] = sync2_q[i];
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end
        end
    end

    // Sticky event flag: a new acceptance wins over a simultaneous ack.
    always_comb begin
        evt_d = evt_q;
        if (|(rise_d | fall_d)) begin
            evt_d = 1'b1;
        end else if (evt_ack) begin
            evt_d = 1'b0;
        end else begin
            evt_d = evt_q;
        end
    end

    // State registers; reset restores the synchroniser and outputs with no strobe.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
            data_q  <= RESET_VALUE;
            rise_q  <= {WIDTH{1'b0}};
            fall_q  <= {WIDTH{1'b0}};
            evt_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            data_q  <= data_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign data_out  = data_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign evt_valid = evt_q;

endmodule

// File: tb/tb_sm_input_debounce.sv
// Directed bench for sm_input_debounce with DEBOUNCE_CYCLES=4, WIDTH=6.
module tb_sm_input_debounce;

    localparam int W = 6;

    logic         clkIn;
    logic         rst_n;
    logic [W-1:0] din;
    logic [W-1:0] data_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         evt_valid;
    logic         evt_ack;

    int n_checks;
    int n_fail;

    sm_input_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (6'h00)
    ) dut (
        .clkIn     (clkIn),
        .rst_n     (rst_n),
        .din       (din),
        .data_out  (data_out),
        .rise      (rise),
        .fall      (fall),
        .evt_valid (evt_valid),
        .evt_ack   (evt_ack)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] d, input logic [W-1:0] r,
                             input logic [W-1:0] f, input logic e);
        check_eq({tag, ".data"}, {26'd0, data_out}, {26'd0, d});
        check_eq({tag, ".rise"}, {26'd0, rise}, {26'd0, r});
        check_eq({tag, ".fall"}, {26'd0, fall}, {26'd0, f});
        check_eq({tag, ".evt"}, {31'd0, evt_valid}, {31'd0, e});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        din      = 6'h00;
        evt_ack  = 1'b0;
        #1;
        check_all("reset", 6'h00, 6'h00, 6'h00, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Quiet inputs stay quiet.
        for (int k = 1; k <= 20; k++) begin
            tick();
            check_all("idle", 6'h00, 6'h00, 6'h00, 1'b0);
        end

        // 0x00 -> 0x05: accepted at edge 6, rise for one cycle.
        din = 6'h05;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       check_all("rise5.pre", 6'h00, 6'h00, 6'h00, 1'b0);
            else if (k == 6) check_all("rise5.acc", 6'h05, 6'h05, 6'h00, 1'b1);
            else             check_all("rise5.post", 6'h05, 6'h00, 6'h00, 1'b1);
        end

        // Three-cycle low glitches on bit 0 are rejected.
        for (int p = 0; p < 5; p++) begin
            din = 6'h04;
            for (int k = 0; k < 3; k++) begin
                tick();
                check_all("glitch", 6'h05, 6'h00, 6'h00, 1'b1);
            end
            din = 6'h05;
            tick();
            check_all("glitch", 6'h05, 6'h00, 6'h00, 1'b1);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check_all("glitch.flush", 6'h05, 6'h00, 6'h00, 1'b1);
        end

        // Bit 2 falls; ack lands on the accepting edge, set wins.
        din = 6'h01;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_all("fall2.pre", 6'h05, 6'h00, 6'h00, 1'b1);
        end
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check_all("fall2.ack", 6'h01, 6'h00, 6'h04, 1'b1);
        tick();
        check_all("fall2.post", 6'h01, 6'h00, 6'h00, 1'b1);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check_all("ack.clear", 6'h01, 6'h00, 6'h00, 1'b0);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check_all("ack.idle", 6'h01, 6'h00, 6'h00, 1'b0);

        // Reset mid-count discards progress.
        din = 6'h3F;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_all("mid.pre", 6'h01, 6'h00, 6'h00, 1'b0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_all("mid.rst", 6'h00, 6'h00, 6'h00, 1'b0);
        #4;
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)       check_all("rel.pre", 6'h00, 6'h00, 6'h00, 1'b0);
            else if (k == 6) check_all("rel.acc", 6'h3F, 6'h3F, 6'h00, 1'b1);
            else             check_all("rel.post", 6'h3F, 6'h00, 6'h00, 1'b1);
        end

        // Prepare bit 0 low, then stagger rise[0] and fall[5] by two cycles.
        din = 6'h3E;
        for (int k = 1; k <= 6; k++) tick();
        check_all("prep", 6'h3E, 6'h00, 6'h01, 1'b1);
        tick();
        din = 6'h3F;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) din = 6'h1F;
            if (k < 6)       check_all("stag.a", 6'h3E, 6'h00, 6'h00, 1'b1);
            else if (k == 6) check_all("stag.r0", 6'h3F, 6'h01, 6'h00, 1'b1);
            else if (k == 7) check_all("stag.b", 6'h3F, 6'h00, 6'h00, 1'b1);
            else if (k == 8) check_all("stag.f5", 6'h1F, 6'h00, 6'h20, 1'b1);
            else             check_all("stag.c", 6'h1F, 6'h00, 6'h00, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
